// File: rtl/count_irq_monitor.sv
// Wishbone-programmable event monitor on the user-project counter bus: two compare
// channels, a wrap channel with a saturating tally, sticky W1C status driving user_irq.
module count_irq_monitor #(
    parameter int          BITS     = 30,
    parameter logic [31:0] BASE_ADR = 32'h3000_0100
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [BITS-1:0] count_i,
    output logic [2:0]      user_irq
);

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_CMP0    = 3'd1;
    localparam logic [2:0] REG_CMP1    = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_WRAPCNT = 3'd4;
    localparam logic [2:0] REG_PREV    = 3'd5;

    logic [2:0]      ctrl;
    logic [BITS-1:0] cmp0;
    logic [BITS-1:0] cmp1;
    logic [2:0]      status;
    logic [15:0]     wrapcnt;
    logic [BITS-1:0] prev;
    logic            ack_q;
    logic [31:0]     dat_q;

    // Bus handshake: a hit is cyc & stb inside the 32-byte window. The access is
    // accepted (write committed, read data captured) on the edge where hit & ~ack,
    // and ack is high for exactly the following cycle; a strobe still held after
    // that ack is taken as a fresh access, so it gets an ack every second cycle.
    logic       hit;
    logic       acc;
    logic       wr;
    logic       rd;
    logic [2:0] reg_sel;

    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADR[31:5]);
    assign acc     = hit & ~ack_q;
    assign wr      = acc & wbs_we_i;
    assign rd      = acc & ~wbs_we_i;
    assign reg_sel = wbs_adr_i[4:2];

    function automatic logic [31:0] byte_merge(input logic [31:0] old_d,
                                               input logic [31:0] new_d,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_d;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_d[8*b +: 8];
        end
        return res;
    endfunction

    logic [31:0] cmp0_merge;
    logic [31:0] cmp1_merge;

    assign cmp0_merge = byte_merge(32'(cmp0), wbs_dat_i, wbs_sel_i);
    assign cmp1_merge = byte_merge(32'(cmp1), wbs_dat_i, wbs_sel_i);

    // Events compare the live count against the previous sample, so a count that
    // sits on a compare value fires only once, on entry.
    logic ev_m0;
    logic ev_m1;
    logic ev_w;

    assign ev_m0 = (count_i == cmp0) && (prev != cmp0);
    assign ev_m1 = (count_i == cmp1) && (prev != cmp1);
    assign ev_w  = count_i < prev;

    logic [2:0]  status_clr;
    logic [2:0]  status_nxt;
    logic        wc_clr;
    logic [15:0] wc_nxt;

    always_comb begin
        status_clr = 3'b000;
        if (wr && reg_sel == REG_STATUS && wbs_sel_i[0]) status_clr = wbs_dat_i[2:0];
        // Event set has priority over a same-edge clear.
        status_nxt = (status & ~status_clr) | {ev_w, ev_m1, ev_m0};
    end

    always_comb begin
        wc_clr = wr && reg_sel == REG_WRAPCNT && (|wbs_sel_i);
        wc_nxt = wrapcnt;
        if (wc_clr)                        wc_nxt = ev_w ? 16'd1 : 16'd0;
        else if (ev_w && wrapcnt != 16'hFFFF) wc_nxt = wrapcnt + 16'd1;
    end

    logic [31:0] rdata;

    always_comb begin
        rdata = 32'h0;
        case (reg_sel)
            REG_CTRL:    rdata = {29'h0, ctrl};
            REG_CMP0:    rdata = 32'(cmp0);
            REG_CMP1:    rdata = 32'(cmp1);
            REG_STATUS:  rdata = {29'h0, status};
            REG_WRAPCNT: rdata = {16'h0, wrapcnt};
            REG_PREV:    rdata = 32'(prev);
            default:     rdata = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ctrl    <= 3'b000;
            cmp0    <= '0;
            cmp1    <= '0;
            status  <= 3'b000;
            wrapcnt <= 16'h0;
            prev    <= '0;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0;
        end else begin
            prev    <= count_i;
            status  <= status_nxt;
            wrapcnt <= wc_nxt;
            ack_q   <= acc;
            dat_q   <= rd ? rdata : 32'h0;
            if (wr) begin
                case (reg_sel)
                    REG_CTRL: if (wbs_sel_i[0]) ctrl <= wbs_dat_i[2:0];
                    REG_CMP0: cmp0 <= cmp0_merge[BITS-1:0];
                    REG_CMP1: cmp1 <= cmp1_merge[BITS-1:0];
                    default:  ;
                endcase
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign user_irq  = status & ctrl;

    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], cmp0_merge[31:BITS], cmp1_merge[31:BITS]};

endmodule

// File: tb/tb_count_irq_monitor.sv
// Directed bench for count_irq_monitor: hand-computed expectations checked with
// immediate assertions along one linear stimulus sequence.
module tb_count_irq_monitor;

    localparam logic [31:0] BASE = 32'h3000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [29:0] count = 30'h0;
    logic [2:0]  irq;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] d;

    count_irq_monitor #(.BITS(30), .BASE_ADR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .count_i  (count),
        .user_irq (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_start(input logic [7:0] off, input logic w, input logic [31:0] wd,
                            input logic [3:0] s);
        adr = BASE + {24'h0, off};
        we  = w;
        dat = wd;
        sel = s;
        cyc = 1'b1;
        stb = 1'b1;
    endtask

    task automatic wait_ack(input string tag, output logic [31:0] rd);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ack) break;
        end
        check(tag, {31'h0, ack}, 32'h1);
        rd = rdat;
    endtask

    task automatic wb_end();
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        sel = 4'h0;
        tick();
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] s);
        logic [31:0] unused_rd;
        wb_start(off, 1'b1, wd, s);
        wait_ack("wr_ack", unused_rd);
        wb_end();
    endtask

    task automatic wb_read_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        wb_start(off, 1'b0, 32'h0, 4'hF);
        wait_ack({tag, "_ack"}, rd);
        wb_end();
        check(tag, rd, exp);
    endtask

    initial begin
        // Reset state and first sample with CMPn=0, count=0
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", {29'h0, irq}, 32'h0);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_irq", {29'h0, irq}, 32'h0);
        wb_read_chk("rst_ctrl", 8'h00, 32'h0);
        wb_read_chk("rst_cmp0", 8'h04, 32'h0);
        wb_read_chk("rst_status", 8'h0C, 32'h0);
        wb_read_chk("rst_wrapcnt", 8'h10, 32'h0);
        wb_read_chk("rst_prev", 8'h14, 32'h0);

        // CMP0 entry on an upward ramp
        wb_write(8'h04, 32'h7, 4'hF);
        wb_write(8'h00, 32'h1, 4'hF);
        for (int v = 0; v <= 10; v++) begin
            count = 30'(v);
            tick();
            check("ramp_irq0", {31'h0, irq[0]}, 32'(v >= 7));
        end
        count = 30'd7;  // 10 -> 7 is also a wrap
        tick();
        wb_write(8'h0C, 32'h1, 4'hF);
        tick();
        tick();
        tick();
        check("hold7_irq0", {31'h0, irq[0]}, 32'h0);
        wb_read_chk("hold7_status", 8'h0C, 32'h4);
        wb_write(8'h0C, 32'h4, 4'hF);
        wb_write(8'h10, 32'h0, 4'hF);
        wb_read_chk("clr_status", 8'h0C, 32'h0);
        wb_read_chk("clr_wrapcnt", 8'h10, 32'h0);

        // CMP1 at full scale with EN1 off, then enabled
        wb_write(8'h08, 32'h3FFF_FFFF, 4'hF);
        count = 30'h3FFF_FFFF;
        tick();
        check("cmp1_dis_irq", {29'h0, irq}, 32'h0);
        wb_read_chk("cmp1_status", 8'h0C, 32'h2);
        wb_write(8'h00, 32'h3, 4'hF);
        check("cmp1_en_irq", {29'h0, irq}, 32'h2);

        // Three wraps with ENW
        count = 30'h3FFF_FFFE;
        tick();
        wb_write(8'h0C, 32'h7, 4'hF);
        wb_write(8'h10, 32'h0, 4'hF);
        wb_write(8'h00, 32'h7, 4'hF);
        check("pre_wrap_irq", {29'h0, irq}, 32'h0);
        for (int n = 0; n < 3; n++) begin
            count = 30'h3FFF_FFFE;
            tick();
            count = 30'h3FFF_FFFF;
            tick();
            count = 30'h2;
            tick();
        end
        check("wrap_irq", {29'h0, irq}, 32'h6);
        wb_read_chk("wrapcnt3", 8'h10, 32'h3);
        wb_read_chk("prev2", 8'h14, 32'h2);
        wb_write(8'h10, 32'h0, 4'b0100);
        wb_read_chk("wrapcnt_clr", 8'h10, 32'h0);

        // W1C of S0 on the same edge as CMP0 entry: set wins
        count = 30'd7;
        tick();
        count = 30'd3;
        tick();
        wb_start(8'h0C, 1'b1, 32'h1, 4'h1);
        count = 30'd7;
        wait_ack("w1c_race_ack", d);
        wb_end();
        wb_read_chk("w1c_race_status", 8'h0C, 32'h7);

        // WRAPCNT clear on the same edge as a wrap leaves 1
        wb_start(8'h10, 1'b1, 32'h0, 4'h1);
        count = 30'd1;
        wait_ack("wc_race_ack", d);
        wb_end();
        wb_read_chk("wc_race", 8'h10, 32'h1);

        // Byte-lane write, reserved offset, off-window access
        wb_write(8'h04, 32'h1234, 4'hF);
        wb_write(8'h04, 32'hAB00, 4'b0010);
        wb_read_chk("cmp0_bytes", 8'h04, 32'hAB34);
        wb_read_chk("rsvd_1c", 8'h1C, 32'h0);
        wb_start(8'h20, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("offwin_ack", {31'h0, ack}, 32'h0);
        end
        wb_end();

        // Held strobe acks every second cycle
        wb_start(8'h00, 1'b0, 32'h0, 4'hF);
        tick();
        check("held_ack1", {31'h0, ack}, 32'h1);
        tick();
        check("held_ack2", {31'h0, ack}, 32'h0);
        tick();
        check("held_ack3", {31'h0, ack}, 32'h1);
        tick();
        check("held_ack4", {31'h0, ack}, 32'h0);
        wb_end();

        // Asynchronous reset mid-transaction, count=5
        count = 30'd5;
        tick();
        wb_start(8'h00, 1'b0, 32'h0, 4'hF);
        tick();
        check("pre_rst_ack", {31'h0, ack}, 32'h1);
        check("pre_rst_dat", rdat, 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ack", {31'h0, ack}, 32'h0);
        check("async_rst_dat", rdat, 32'h0);
        check("async_rst_irq", {29'h0, irq}, 32'h0);
        we  = 1'b1;
        adr = BASE + 32'h8;
        dat = 32'h55;
        tick();
        tick();
        wb_end();
        rst_n = 1'b1;
        tick();
        wb_read_chk("rst2_ctrl", 8'h00, 32'h0);
        wb_read_chk("rst2_cmp0", 8'h04, 32'h0);
        wb_read_chk("rst2_cmp1", 8'h08, 32'h0);
        wb_read_chk("rst2_status", 8'h0C, 32'h0);
        wb_read_chk("rst2_wrapcnt", 8'h10, 32'h0);
        wb_read_chk("rst2_prev", 8'h14, 32'h5);
        check("rst2_irq", {29'h0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
